pkt_filter_1: RTL and testbench
===============================

PKT_FILTER_1 -- requirements
Module: pkt_filter_1

Interface
Parameters:
REQ-001 C_S_AXIS_DATA_WIDTH, default 512: AXI-Stream data width in bits; tkeep width is C_S_AXIS_DATA_WIDTH/8.
REQ-002 C_S_AXIS_TUSER_WIDTH, default 128: AXI-Stream tuser width in bits.

Ports:
REQ-003 clk  in  1  single clock; all logic on the rising edge.
REQ-004 aresetn  in  1  reset, synchronous, active-low.
REQ-005 s_axis_tdata/tkeep/tuser/tvalid/tlast  in  512/64/128/1/1  ingress stream; byte 0 of the frame is tdata[7:0].
REQ-006 s_axis_tready  out  1  ingress ready.
REQ-007 m_axis_tdata/tkeep/tuser/tvalid/tlast  out  512/64/128/1/1  data-path egress stream.
REQ-008 m_axis_tready  in  1  data-path egress ready.
REQ-009 c_m_axis_tdata/tkeep/tuser/tvalid/tlast  out  512/64/128/1/1  control-path egress stream; it has no ready input.

Function
REQ-010 Classify each packet on its first beat (the first s_axis_tvalid beat after reset or after a tlast beat).
- Control packet: all three conditions hold:
  - tdata[143:128]==16'h0008 (IPv4 ethertype after the 802.1Q tag);
  - tdata[223:216]==8'h11 (UDP);
  - tdata[335:320]==16'hf1f2 (control UDP destination port).
- Any other packet is a data packet.
REQ-011 State machine, three states:
- IDLE: on a first beat, latch the classification.
  - If that beat has tlast=0, go to FWD_DATA or FWD_CTRL.
  - If that beat has tlast=1, stay in IDLE.
- FWD_DATA and FWD_CTRL: return to IDLE on an accepted beat with tlast=1.
REQ-012 A beat is accepted when s_axis_tvalid and s_axis_tready are both 1.
REQ-013 Every beat of a data packet, including the first, is output on m_axis exactly one clock after acceptance, with tdata, tkeep, tuser and tlast unmodified.
REQ-014 Every beat of a control packet is output on c_m_axis exactly one clock after acceptance, unmodified; m_axis_tvalid stays 0 for that packet.
REQ-015 All outputs are registered.
- An output's tvalid is 1 for exactly one cycle per beat on the control path.
- On the data path, tvalid holds until m_axis_tready=1.
REQ-016 The data-path output register holds its value while m_axis_tvalid=1 and m_axis_tready=0.
REQ-017 s_axis_tready = m_axis_tready OR NOT m_axis_tvalid, combinationally, in every state.
REQ-018 When s_axis_tvalid=0, no output tvalid asserts in the next cycle, apart from a data beat already held by REQ-016; the state is unchanged.
REQ-019 When output tvalid=0, tdata/tkeep/tuser/tlast are driven to 0 on that output.
REQ-020 A packet is never split across the two outputs; classification is fixed until its tlast.
REQ-021 Back-to-back packets with no idle cycle are classified independently: the beat following a tlast beat is a first beat.

Reset
REQ-022 While aresetn=0 at a rising edge:
- state = IDLE;
- all m_axis_* and c_m_axis_* outputs = 0;
- s_axis_tready follows REQ-017, giving 1.
REQ-023 Reset asserted mid-packet discards the rest of that packet. After release, the next valid beat is treated as a first beat.

Verification
REQ-024 Data packet (4 beats, m_axis_tready=1):
- stimulus: beat 0 with [143:128]=16'h0008, [223:216]=8'h11, [191:176]=16'hf1f2, [335:320]=0, tkeep all-ones; last beat tlast=1;
- required: 4 beats on m_axis, each 1 cycle later, identical data; c_m_axis_tvalid never 1.
REQ-025 Control packet (4 beats):
- stimulus: as REQ-024 but [335:320]=16'hf1f2;
- required: 4 beats on c_m_axis, 1-cycle latency, last with c_m_axis_tlast=1; m_axis_tvalid stays 0.
REQ-026 Non-IPv4 (ethertype 16'h0000) or non-UDP (protocol 8'h06) packet with port f1f2 -> routed to m_axis.
REQ-027 Back-pressure:
- stimulus: m_axis_tready=0 for 3 cycles during a data packet;
- required: s_axis_tready=0 while the output is held; no beat lost or duplicated; output order preserved.
REQ-028 Mixed traffic:
- stimulus: control packet followed with no gap by a data packet, plus a single-beat (tlast on first beat) data packet;
- required: each packet appears whole on the correct output.
- stimulus: reset pulsed mid-packet;
- required: outputs 0 the next cycle, and the next packet is classified correctly.

Source files
------------

// File: rtl/pkt_filter_1.sv
// pkt_filter_1: AXI-Stream packet splitter.
// Each packet is classified on its first beat. UDP/IPv4 packets with
// destination port 0xf1f2 (VLAN-tagged frame layout) go to the control
// egress c_m_axis. All other packets go to the data egress m_axis.
// Both egress streams are registered and add one cycle of latency.
// The control egress has no back-pressure. Ingress ready follows the
// data-path output register only.
module pkt_filter_1 #(
    parameter int C_S_AXIS_DATA_WIDTH  = 512,
    parameter int C_S_AXIS_TUSER_WIDTH = 128
) (
    input  logic                              clk,
    input  logic                              aresetn,

    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                              s_axis_tvalid,
    input  logic                              s_axis_tlast,
    output logic                              s_axis_tready,

    output logic [C_S_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                              m_axis_tvalid,
    output logic                              m_axis_tlast,
    input  logic                              m_axis_tready,

    output logic [C_S_AXIS_DATA_WIDTH-1:0]    c_m_axis_tdata,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  c_m_axis_tkeep,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]   c_m_axis_tuser,
    output logic                              c_m_axis_tvalid,
    output logic                              c_m_axis_tlast
);

    localparam int KW = C_S_AXIS_DATA_WIDTH / 8;

    // Header fields used for classification (byte 0 of the frame is tdata[7:0]).
    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0008;
    localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;
    localparam logic [15:0] CTRL_UDP_PORT  = 16'hf1f2;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FWD_DATA = 2'd1,
        ST_FWD_CTRL = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Data-path output register. It holds its value under back-pressure.
    logic [C_S_AXIS_DATA_WIDTH-1:0]  r_m_tdata;
    logic [KW-1:0]                   r_m_tkeep;
    logic [C_S_AXIS_TUSER_WIDTH-1:0] r_m_tuser;
    logic                            r_m_tvalid;
    logic                            r_m_tlast;

    // Control-path output register. It is a one-cycle pulse per beat.
    logic [C_S_AXIS_DATA_WIDTH-1:0]  r_c_tdata;
    logic [KW-1:0]                   r_c_tkeep;
    logic [C_S_AXIS_TUSER_WIDTH-1:0] r_c_tuser;
    logic                            r_c_tvalid;
    logic                            r_c_tlast;

    logic w_hdr_is_ctrl;
    logic w_accept;
    logic w_beat_ctrl;
    logic w_load_data;
    logic w_load_ctrl;

    // Ingress may advance whenever the data register is empty or draining.
    // The control path never stalls, so it plays no part in ready.
    assign s_axis_tready = m_axis_tready | ~r_m_tvalid;
    assign w_accept      = s_axis_tvalid & s_axis_tready;

    // First-beat header match. This is only meaningful when the state is IDLE.
    assign w_hdr_is_ctrl = (s_axis_tdata[143:128] == ETHERTYPE_IPV4) &&
                           (s_axis_tdata[223:216] == IP_PROTO_UDP)   &&
                           (s_axis_tdata[335:320] == CTRL_UDP_PORT);

    // State register: tracks which egress owns the packet in flight.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments. Every
        // always_ff then sees pre-edge values, with no dependence on
        // evaluation order.
        if (!aresetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: open a packet on a non-final first beat, close it on tlast.
    always_comb begin
        // NOTE: default first, so every path assigns and no latch is inferred.
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && !s_axis_tlast) begin
                    w_state_next = w_hdr_is_ctrl ? ST_FWD_CTRL : ST_FWD_DATA;
                end
            end
            ST_FWD_DATA,
            ST_FWD_CTRL: begin
                if (w_accept && s_axis_tlast) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Output decode: route the accepted beat using the latched or fresh class.
    always_comb begin
        w_beat_ctrl = 1'b0;
        case (r_state)
            ST_IDLE:     w_beat_ctrl = w_hdr_is_ctrl;
            ST_FWD_CTRL: w_beat_ctrl = 1'b1;
            ST_FWD_DATA: w_beat_ctrl = 1'b0;
            default:     w_beat_ctrl = 1'b0;
        endcase
        w_load_data = w_accept && !w_beat_ctrl;
        w_load_ctrl = w_accept &&  w_beat_ctrl;
    end

    // Data egress register: load on a data beat, clear when drained, hold when stalled.
    always_ff @(posedge clk) begin
        // NOTE: the wide payload registers are reset and cleared as well as
        // the valid bit, because the egress payload must read as zero
        // whenever valid is low.
        if (!aresetn) begin
            r_m_tdata  <= '0;
            r_m_tkeep  <= '0;
            r_m_tuser  <= '0;
            r_m_tvalid <= 1'b0;
            r_m_tlast  <= 1'b0;
        end else if (w_load_data) begin
            r_m_tdata  <= s_axis_tdata;
            r_m_tkeep  <= s_axis_tkeep;
            r_m_tuser  <= s_axis_tuser;
            r_m_tvalid <= 1'b1;
            r_m_tlast  <= s_axis_tlast;
        end else if (m_axis_tready) begin
            r_m_tdata  <= '0;
            r_m_tkeep  <= '0;
            r_m_tuser  <= '0;
            r_m_tvalid <= 1'b0;
            r_m_tlast  <= 1'b0;
        end
    end

    // Control egress register: one-cycle copy of each accepted control beat.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            r_c_tdata  <= '0;
            r_c_tkeep  <= '0;
            r_c_tuser  <= '0;
            r_c_tvalid <= 1'b0;
            r_c_tlast  <= 1'b0;
        end else if (w_load_ctrl) begin
            r_c_tdata  <= s_axis_tdata;
            r_c_tkeep  <= s_axis_tkeep;
            r_c_tuser  <= s_axis_tuser;
            r_c_tvalid <= 1'b1;
            r_c_tlast  <= s_axis_tlast;
        end else begin
            r_c_tdata  <= '0;
            r_c_tkeep  <= '0;
            r_c_tuser  <= '0;
            r_c_tvalid <= 1'b0;
            r_c_tlast  <= 1'b0;
        end
    end

    assign m_axis_tdata    = r_m_tdata;
    assign m_axis_tkeep    = r_m_tkeep;
    assign m_axis_tuser    = r_m_tuser;
    assign m_axis_tvalid   = r_m_tvalid;
    assign m_axis_tlast    = r_m_tlast;

    assign c_m_axis_tdata  = r_c_tdata;
    assign c_m_axis_tkeep  = r_c_tkeep;
    assign c_m_axis_tuser  = r_c_tuser;
    assign c_m_axis_tvalid = r_c_tvalid;
    assign c_m_axis_tlast  = r_c_tlast;

endmodule

// File: tb/tb_pkt_filter_1.sv
// Testbench for pkt_filter_1. Directed packets are driven on the ingress.
// A behavioural model predicts both egress streams every cycle.
// Per-output FIFO scoreboards check order and completeness.
// Hand-computed beat counts pin the model for each scenario.
module tb_pkt_filter_1;

    localparam int DW = 512;
    localparam int UW = 128;
    localparam int KW = DW / 8;

    typedef struct packed {
        logic          last;
        logic [UW-1:0] user;
        logic [KW-1:0] keep;
        logic [DW-1:0] data;
    } beat_t;

    logic          clk = 1'b0;
    logic          aresetn;
    logic [DW-1:0] s_tdata;
    logic [KW-1:0] s_tkeep;
    logic [UW-1:0] s_tuser;
    logic          s_tvalid, s_tlast, s_tready;
    logic [DW-1:0] m_tdata;
    logic [KW-1:0] m_tkeep;
    logic [UW-1:0] m_tuser;
    logic          m_tvalid, m_tlast, m_tready;
    logic [DW-1:0] c_tdata;
    logic [KW-1:0] c_tkeep;
    logic [UW-1:0] c_tuser;
    logic          c_tvalid, c_tlast;

    always #5 clk = ~clk;

    pkt_filter_1 #(.C_S_AXIS_DATA_WIDTH(DW), .C_S_AXIS_TUSER_WIDTH(UW)) dut (
        .clk(clk), .aresetn(aresetn),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tuser(s_tuser),
        .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast), .s_axis_tready(s_tready),
        .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tuser(m_tuser),
        .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast), .m_axis_tready(m_tready),
        .c_m_axis_tdata(c_tdata), .c_m_axis_tkeep(c_tkeep), .c_m_axis_tuser(c_tuser),
        .c_m_axis_tvalid(c_tvalid), .c_m_axis_tlast(c_tlast)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [767:0] act, input logic [767:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit    chk_en = 1'b0;
    bit    mdl_acc = 1'b0;      // the beat presented before the last edge was taken
    bit    in_pkt = 1'b0;       // a packet is open (first beat seen, no tlast yet)
    bit    pkt_ctrl = 1'b0;     // class of the open packet
    bit    exp_m_v = 1'b0;
    bit    exp_c_v = 1'b0;
    beat_t exp_m = '0;
    beat_t exp_c = '0;
    beat_t q_m[$];
    beat_t q_c[$];
    int    cnt_m = 0;
    int    cnt_c = 0;

    function automatic bit is_control(input logic [DW-1:0] d);
        return (d[143:128] == 16'h0008) && (d[223:216] == 8'h11) && (d[335:320] == 16'hf1f2);
    endfunction

    always @(posedge clk) begin : model
        beat_t in_b;
        beat_t dut_b;
        bit    cls;
        // Scoreboard: whatever the DUT hands over must be the next expected beat.
        if (chk_en && m_tvalid && m_tready) begin
            cnt_m++;
            dut_b.data = m_tdata; dut_b.keep = m_tkeep; dut_b.user = m_tuser; dut_b.last = m_tlast;
            if (q_m.size() == 0) check("m_unexpected_beat", dut_b, '0);
            else check("m_order", dut_b, q_m.pop_front());
        end
        if (chk_en && c_tvalid) begin
            cnt_c++;
            dut_b.data = c_tdata; dut_b.keep = c_tkeep; dut_b.user = c_tuser; dut_b.last = c_tlast;
            if (q_c.size() == 0) check("c_unexpected_beat", dut_b, '0);
            else check("c_order", dut_b, q_c.pop_front());
        end

        in_b.data = s_tdata; in_b.keep = s_tkeep; in_b.user = s_tuser; in_b.last = s_tlast;
        if (!aresetn) begin
            chk_en   = 1'b1;
            mdl_acc  = 1'b0;
            in_pkt   = 1'b0;
            pkt_ctrl = 1'b0;
            exp_m_v  = 1'b0; exp_m = '0;
            exp_c_v  = 1'b0; exp_c = '0;
            q_m.delete();
            q_c.delete();
        end else begin
            mdl_acc = s_tvalid && (m_tready || !exp_m_v);
            cls     = in_pkt ? pkt_ctrl : is_control(s_tdata);
            exp_c_v = mdl_acc && cls;
            exp_c   = exp_c_v ? in_b : '0;
            if (mdl_acc && !cls) begin
                exp_m_v = 1'b1; exp_m = in_b;
                q_m.push_back(in_b);
            end else if (m_tready) begin
                exp_m_v = 1'b0; exp_m = '0;
            end
            if (exp_c_v) q_c.push_back(in_b);
            if (mdl_acc) begin
                in_pkt   = !s_tlast;
                pkt_ctrl = cls;
            end
        end
    end

    // Per-cycle compare, half a cycle after the active edge.
    always @(negedge clk) begin
        beat_t dm, dc;
        if (chk_en) begin
            dm.data = m_tdata; dm.keep = m_tkeep; dm.user = m_tuser; dm.last = m_tlast;
            dc.data = c_tdata; dc.keep = c_tkeep; dc.user = c_tuser; dc.last = c_tlast;
            check("s_tready", s_tready, m_tready || !exp_m_v);
            check("m_tvalid", m_tvalid, exp_m_v);
            check("m_payload", dm, exp_m);
            check("c_tvalid", c_tvalid, exp_c_v);
            check("c_payload", dc, exp_c);
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [DW-1:0] mk_hdr(input logic [15:0] et, input logic [7:0] proto,
                                            input logic [15:0] port_hi, input logic [15:0] port_lo);
        logic [DW-1:0] d;
        d = {16{32'h0bad_f00d}};
        d[143:128] = et;
        d[223:216] = proto;
        d[335:320] = port_hi;
        d[191:176] = port_lo;
        return d;
    endfunction

    // Present one beat (called just after a falling edge) and wait until it is taken.
    task automatic drive_beat(input beat_t b);
        #1;
        s_tvalid = 1'b1;
        s_tdata  = b.data;
        s_tkeep  = b.keep;
        s_tuser  = b.user;
        s_tlast  = b.last;
        for (int k = 0; ; k++) begin
            @(negedge clk);
            if (mdl_acc) break;
            if (k >= 200) begin
                n_checks++;
                n_fail++;
                $display("FAIL accept_timeout: beat not taken within 200 cycles");
                break;
            end
        end
    endtask

    // Send beats 0..n_send-1 of an n_beats packet; n_send < n_beats leaves it open.
    task automatic send_pkt(input logic [DW-1:0] hdr, input int n_beats, input int n_send,
                            input logic [7:0] seed);
        beat_t b;
        logic [31:0] w;
        for (int i = 0; i < n_send; i++) begin
            w      = {seed, 8'(i), 16'ha5c3};
            b.data = (i == 0) ? hdr : {16{w}};
            b.keep = (i == n_beats - 1) ? 64'h0000_0000_00ff_ffff : '1;
            b.user = {112'h0, seed, 8'(i)};
            b.last = (i == n_beats - 1);
            drive_beat(b);
        end
    endtask

    task automatic idle(input int n);
        #1;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        s_tkeep  = '0;
        s_tuser  = '0;
        s_tlast  = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic clr_counts();
        cnt_m = 0;
        cnt_c = 0;
    endtask

    logic [DW-1:0] h_data, h_ctrl, h_noip, h_tcp;

    initial begin
        aresetn  = 1'b0;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        s_tkeep  = '0;
        s_tuser  = '0;
        s_tlast  = 1'b0;
        m_tready = 1'b1;
        h_data = mk_hdr(16'h0008, 8'h11, 16'h0000, 16'hf1f2);
        h_ctrl = mk_hdr(16'h0008, 8'h11, 16'hf1f2, 16'hf1f2);
        h_noip = mk_hdr(16'h0000, 8'h11, 16'hf1f2, 16'h0000);
        h_tcp  = mk_hdr(16'h0008, 8'h06, 16'hf1f2, 16'h0000);

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_s_tready", s_tready, 1'b1);
        check("rst_m_tvalid", m_tvalid, 1'b0);
        check("rst_c_tvalid", c_tvalid, 1'b0);
        check("rst_m_tdata", m_tdata, '0);
        #1 aresetn = 1'b1;
        @(negedge clk);

        // Data packet: port f1f2 sits in the wrong field.
        clr_counts();
        send_pkt(h_data, 4, 4, 8'h10);
        idle(3);
        check("data_m_beats", cnt_m, 4);
        check("data_c_beats", cnt_c, 0);

        // Control packet.
        clr_counts();
        send_pkt(h_ctrl, 4, 4, 8'h20);
        idle(3);
        check("ctrl_c_beats", cnt_c, 4);
        check("ctrl_m_beats", cnt_m, 0);

        // Non-IPv4 and non-UDP packets carrying port f1f2 go to data.
        clr_counts();
        send_pkt(h_noip, 3, 3, 8'h30);
        idle(1);
        send_pkt(h_tcp, 2, 2, 8'h31);
        idle(3);
        check("noip_tcp_m_beats", cnt_m, 5);
        check("noip_tcp_c_beats", cnt_c, 0);

        // Back-pressure: m_tready low for 3 cycles mid-packet.
        clr_counts();
        fork
            send_pkt(h_data, 6, 6, 8'h40);
            begin
                repeat (3) @(negedge clk);
                #1 m_tready = 1'b0;
                @(negedge clk);
                check("bp_hold_s_tready", s_tready, 1'b0);
                check("bp_hold_m_tvalid", m_tvalid, 1'b1);
                repeat (2) @(negedge clk);
                #1 m_tready = 1'b1;
            end
        join
        idle(3);
        check("bp_m_beats", cnt_m, 6);

        // Mixed: control then data back-to-back, then single-beat packets.
        clr_counts();
        send_pkt(h_ctrl, 3, 3, 8'h50);
        send_pkt(h_data, 2, 2, 8'h51);
        send_pkt(h_data, 1, 1, 8'h52);
        send_pkt(h_ctrl, 1, 1, 8'h53);
        send_pkt(h_tcp, 2, 2, 8'h54);
        idle(3);
        check("mixed_c_beats", cnt_c, 4);
        check("mixed_m_beats", cnt_m, 5);

        // Reset in the middle of a data packet.
        send_pkt(h_data, 4, 2, 8'h60);
        #1 aresetn = 1'b0;
        @(negedge clk);
        check("midrst_m_tvalid", m_tvalid, 1'b0);
        check("midrst_c_tvalid", c_tvalid, 1'b0);
        check("midrst_s_tready", s_tready, 1'b1);
        #1 aresetn = 1'b1;
        idle(1);
        clr_counts();
        send_pkt(h_ctrl, 2, 2, 8'h70);
        idle(3);
        check("postrst_c_beats", cnt_c, 2);
        check("postrst_m_beats", cnt_m, 0);

        check("q_m_drained", q_m.size(), 0);
        check("q_c_drained", q_c.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
